data_mem_lsu: RTL

//  Parametrised, handshaked data memory for the RISC-V core's MEM stage; successor to the combinational-read data memory.

---
 rtl/dmem_pkg.sv | 10 +
 rtl/dmem_load_align.sv | 11 +
 rtl/data_mem_lsu.sv | 103 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and the load sign/zero-extension helper for the data memory LSU.
package dmem_pkg;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input size_e size, input logic zext);
        return size == SZ_BYTE ? {{24{raw[7] & ~zext}}, raw[7:0]} :
               size == SZ_HALF ? {{16{raw[15] & ~zext}}, raw[15:0]} : raw;
    endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: turns the little-endian bytes read at the access address into the response word.
import dmem_pkg::*;
module dmem_load_align (
    input  logic [31:0] raw,
    input  size_e       size,
    input  logic        zext,
    input  logic        kill,
    output logic [31:0] rdata
);
    always_comb rdata = kill ? '0 : load_extend(raw, size, zext);
endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: handshaked byte-lane data memory with LATENCY-cycle access and range/size faults.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of serving them byte-wise.
import dmem_pkg::*;
module data_mem_lsu #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_BYTES = 131072,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_ctrl,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    state_e                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q;
    logic [2:0]            ctrl_q;
    size_e                 size_q;
    logic [7:0]            mem [DEPTH_BYTES];
    logic [AW-1:0]         idx [4];
    logic [3:0]            lane_en;
    logic [2:0]            nbytes;
    logic [32:0]           end_addr;
    logic                  misalign, err, done;
    logic [31:0]           raw, load_data;

    assign size_q = size_e'(ctrl_q[1:0]);

    always_comb begin
        nbytes   = size_q == SZ_BYTE ? 3'd1 : size_q == SZ_HALF ? 3'd2 : 3'd4;
        end_addr = {1'b0, addr_q} + {30'd0, nbytes};
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (size_q == SZ_HALF && addr_q[0]) || (size_q == SZ_WORD && addr_q[1:0] != 2'd0);
`else
        misalign = 1'b0;
`endif
        // Spanning past the top is a fault: byte indices wrap in AW bits, so this guard is what stops aliasing.
        err      = size_q == SZ_BAD || end_addr > 33'(DEPTH_BYTES) || misalign;
        done     = state == ACCESS && cnt == '0;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign idx[g]          = addr_q[AW-1:0] + AW'(g);
        assign raw[8*g +: 8]   = mem[idx[g]];
        assign lane_en[g]      = 3'(g) < nbytes;
    end

    dmem_load_align u_align (
        .raw   (raw),
        .size  (size_q),
        .zext  (ctrl_q[2]),
        .kill  (err || we_q),
        .rdata (load_data)
    );

    always_ff @(posedge clk)
        for (int k = 0; k < 4; k++)
            if (done && we_q && !err && lane_en[k]) mem[idx[k]] <= wdata_q[8*k +: 8];

    always_ff @(posedge clk)
        if (req_valid && req_ready) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            ctrl_q  <= req_ctrl;
            wdata_q <= req_wdata;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (req_valid && req_ready) cnt <= CNT_W'(LATENCY - 1);
            else if (state == ACCESS && cnt != '0) cnt <= cnt - 1'b1;
            if (done) begin
                rsp_rdata <= load_data;
                rsp_err   <= err;
            end
        end

    always_comb
        state_nx = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
                   state == ACCESS ? (cnt == '0 ? RESP : ACCESS) :
                   (rsp_ready ? IDLE : RESP);

    always_comb begin
        req_ready = state == IDLE;
        rsp_valid = state == RESP;
    end
endmodule
